// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types and constants for the unified-memory port arbiter.
//   - arb_state_e : arbiter FSM states
//   - OWNER_IF/LS : encoding of o_owner (0 = fetch, 1 = LSU)
//   - LAT_W       : width of the read-latency counter (RD_LAT-1 for RD_LAT <= 7)
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    localparam int LAT_W = 3;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_arb_picker.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_arb_picker  (arb_picker sub-module)
//   Purely combinational winner selection between fetch and LSU.
//   LSU has fixed priority unless fetch has been passed over STARVE_MAX times
//   in a row while it was waiting.
// Ports:
//   if_req      in   fetch request
//   ls_req      in   LSU request
//   starve_cnt  in   consecutive LSU wins over a pending fetch
//   grant_ls    out  1 = LSU wins, 0 = fetch wins (only meaningful with a request)
//   starve_inc  out  both requested and LSU won
//   starve_clr  out  fetch won
// -----------------------------------------------------------------------------
module mem_port_arbiter_arb_picker #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_req,
    input  logic             ls_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_ls,
    output logic             starve_inc,
    output logic             starve_clr
);

    logic starved;

    assign starved    = (starve_cnt == CNT_W'(STARVE_MAX));

    // A starved fetch only overrides the LSU when fetch is actually asking.
    assign grant_ls   = ls_req && !(if_req && starved);
    assign starve_inc = if_req && ls_req && grant_ls;
    assign starve_clr = if_req && !grant_ls;

endmodule : mem_port_arbiter_arb_picker

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port synchronous memory between the instruction-fetch
//   port and the LSU data port. One transaction in flight; each port is acked
//   with a one-cycle pulse. LSU has priority, a starvation counter forces a
//   waiting fetch through after STARVE_MAX consecutive LSU wins.
// Parameters:
//   ADDR_W      word-address width to memory
//   RD_LAT      memory read latency in cycles (1..7)
//   STARVE_MAX  LSU wins over a pending fetch before fetch is forced through
// Ports:
//   i_clk, i_reset                     clock, async active-low reset
//   i_if_req/addr, o_if_ack/rdata      fetch port
//   i_ls_req/wren/addr/wdata/bmask,
//   o_ls_ack/rdata                     LSU port
//   o_mem_en/wren/addr/wdata/bmask,
//   i_mem_rdata                        memory interface
//   o_busy                             high whenever not IDLE
//   o_owner                            owner of current or last transaction
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [31:0]       i_if_addr,
    output logic              o_if_ack,
    output logic [31:0]       o_if_rdata,
    input  logic              i_ls_req,
    input  logic              i_ls_wren,
    input  logic [31:0]       i_ls_addr,
    input  logic [31:0]       i_ls_wdata,
    input  logic [3:0]        i_ls_bmask,
    output logic              o_ls_ack,
    output logic [31:0]       o_ls_rdata,
    output logic              o_mem_en,
    output logic              o_mem_wren,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_busy,
    output logic              o_owner
);

    localparam int              CNT_W    = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

    arb_state_e       state;
    logic [CNT_W-1:0] starve_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             grant_ls;
    logic             starve_inc;
    logic             starve_clr;

    // Byte-offset bits and bits above the memory size are dropped on purpose:
    // the memory wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_if_addr[31:ADDR_W+2], i_if_addr[1:0],
                                i_ls_addr[31:ADDR_W+2], i_ls_addr[1:0]};

    mem_port_arbiter_arb_picker #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_arb_picker (
        .if_req     (i_if_req),
        .ls_req     (i_ls_req),
        .starve_cnt (starve_cnt),
        .grant_ls   (grant_ls),
        .starve_inc (starve_inc),
        .starve_clr (starve_clr)
    );

    // NOTE: every register here, datapath included, is cleared by the async
    // reset so no output is ever X after reset; state uses non-blocking
    // assignments so all flops update from the same pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ARB_IDLE;
            starve_cnt  <= '0;
            lat_cnt     <= '0;
            o_if_ack    <= 1'b0;
            o_if_rdata  <= '0;
            o_ls_ack    <= 1'b0;
            o_ls_rdata  <= '0;
            o_mem_en    <= 1'b0;
            o_mem_wren  <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= '0;
            o_busy      <= 1'b0;
            o_owner     <= OWNER_IF;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (i_if_req || i_ls_req) begin
                        state    <= ARB_ACCESS;
                        o_mem_en <= 1'b1;
                        o_busy   <= 1'b1;
                        if (grant_ls) begin
                            o_owner     <= OWNER_LS;
                            o_mem_addr  <= i_ls_addr[ADDR_W+1:2];
                            o_mem_wren  <= i_ls_wren;
                            o_mem_wdata <= i_ls_wdata;
                            o_mem_bmask <= i_ls_bmask;
                        end else begin
                            // Fetch never writes.
                            o_owner     <= OWNER_IF;
                            o_mem_addr  <= i_if_addr[ADDR_W+1:2];
                            o_mem_wren  <= 1'b0;
                            o_mem_wdata <= '0;
                            o_mem_bmask <= '0;
                        end
                        if (starve_clr) begin
                            starve_cnt <= '0;
                        end else if (starve_inc) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end

                ARB_ACCESS: begin
                    // Single access strobe; write-side outputs return to 0.
                    o_mem_en    <= 1'b0;
                    o_mem_wren  <= 1'b0;
                    o_mem_wdata <= '0;
                    o_mem_bmask <= '0;
                    if (o_mem_wren) begin
                        // Stores need no read data: ack straight away.
                        state    <= ARB_RESP;
                        o_ls_ack <= 1'b1;
                    end else begin
                        state   <= ARB_WAIT;
                        lat_cnt <= LAT_LOAD;
                    end
                end

                ARB_WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= ARB_RESP;
                        if (o_owner == OWNER_LS) begin
                            o_ls_rdata <= i_mem_rdata;
                            o_ls_ack   <= 1'b1;
                        end else begin
                            o_if_rdata <= i_mem_rdata;
                            o_if_ack   <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                ARB_RESP: begin
                    // Returning to IDLE gives the mandatory one-cycle bubble.
                    state    <= ARB_IDLE;
                    o_if_ack <= 1'b0;
                    o_ls_ack <= 1'b0;
                    o_busy   <= 1'b0;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    a_one_ack : assert property (@(posedge i_clk) disable iff (!i_reset)
        !(o_if_ack && o_ls_ack));

    a_en_in_access : assert property (@(posedge i_clk) disable iff (!i_reset)
        o_mem_en |-> (state == ARB_ACCESS));

endmodule : mem_port_arbiter
